// File: rtl/salsa20_stream_xor_if.sv
// Keystream-chunk and data-stream signals for salsa20_stream_xor.
// master = generator/datapath side, slave = the XOR block.
interface salsa20_stream_xor_if #(
  parameter int DATA_W = 64
);
  logic              ks_initialized;
  logic              ks_ready;
  logic              ks_next_chunk;
  logic [DATA_W-1:0] ks_chunk_key;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output ks_initialized, ks_ready, ks_chunk_key,
    output in_valid, in_data, in_last, out_ready,
    input  ks_next_chunk, in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  ks_initialized, ks_ready, ks_chunk_key,
    input  in_valid, in_data, in_last, out_ready,
    output ks_next_chunk, in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/salsa20_stream_xor.sv
// Buffers Salsa20 keystream blocks and XORs them onto a valid/ready data stream.
// Define SALSA_XOR_PREFETCH_EN for a second bank that is filled while the first streams.
module salsa20_stream_xor #(
  parameter int DATA_W          = 64,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                clk,
  input  logic                rst,
  salsa20_stream_xor_if.slave bus
);
  // state  | meaning
  // IDLE   | generator not initialised, nothing buffered
  // WAIT   | waiting for ks_ready before fetching a block
  // FETCH  | ks_next_chunk high, one keystream word captured per edge
  // STREAM | block buffered and being consumed (prefetch: both banks full)
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH, S_STREAM} state_t;

  localparam int               PTR_W    = $clog2(WORDS_PER_BLOCK);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(WORDS_PER_BLOCK - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  state_t            r_state, w_state_nxt;
  logic [PTR_W-1:0]  r_rd_ptr, r_fetch_cnt, w_wr_idx;
  logic              r_out_valid, r_out_last;
  logic [DATA_W-1:0] r_out_data, w_ks_word;
  logic              w_avail, w_accept, w_ptr_end, w_capture, w_fetch_last;
  logic              w_ks_next, w_in_ready, w_busy;

  assign w_capture    = (r_state == S_FETCH);
  assign w_fetch_last = w_capture && (r_fetch_cnt == '0);
  assign w_wr_idx     = LAST_IDX - r_fetch_cnt;
  assign w_ptr_end    = (r_rd_ptr == LAST_IDX);
  assign w_accept     = bus.in_valid && w_in_ready;

`ifdef SALSA_XOR_PREFETCH_EN
  logic [DATA_W-1:0] r_bank_a [WORDS_PER_BLOCK];
  logic [DATA_W-1:0] r_bank_b [WORDS_PER_BLOCK];
  logic [1:0]        r_full;
  logic              r_act, r_fill, w_fill_sel, w_start, w_discard, w_blk_done;

  // Fill the active bank if it is empty, otherwise the standby bank.
  assign w_fill_sel = r_full[r_act] ? ~r_act : r_act;
  assign w_start    = bus.ks_ready && !(&r_full);
  assign w_avail    = r_full[r_act];
  assign w_ks_word  = r_act ? r_bank_b[r_rd_ptr] : r_bank_a[r_rd_ptr];
  assign w_discard  = w_accept && bus.in_last && !w_ptr_end;
  assign w_blk_done = w_accept && w_ptr_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        r_bank_a[i] <= '0;
        r_bank_b[i] <= '0;
      end
      r_full <= '0;
      r_act  <= 1'b0;
      r_fill <= 1'b0;
    end else begin
      if (r_state == S_WAIT && w_start) r_fill <= w_fill_sel;
      if (w_capture) begin
        if (r_fill) r_bank_b[w_wr_idx] <= bus.ks_chunk_key;
        else        r_bank_a[w_wr_idx] <= bus.ks_chunk_key;
      end
      if (!bus.ks_initialized) begin
        r_full <= '0;
        r_act  <= 1'b0;
      end else begin
        // Mid-block message end drops both banks; a block still arriving becomes active.
        if (w_discard) begin
          r_full <= '0;
          r_act  <= (r_state == S_FETCH) ? r_fill : w_fill_sel;
        end else if (w_blk_done) begin
          r_full[r_act] <= 1'b0;
          r_act         <= ~r_act;
        end
        if (w_fetch_last) r_full[r_fill] <= 1'b1;
      end
    end
  end
`else
  logic [DATA_W-1:0] r_buf [WORDS_PER_BLOCK];

  assign w_avail   = (r_state == S_STREAM);
  assign w_ks_word = r_buf[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) r_buf[i] <= '0;
    end else if (w_capture) begin
      r_buf[w_wr_idx] <= bus.ks_chunk_key;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state != S_IDLE && !bus.ks_initialized) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.ks_initialized) w_state_nxt = S_WAIT;
`ifdef SALSA_XOR_PREFETCH_EN
        S_WAIT:   if (w_start) w_state_nxt = S_FETCH;
                  else if (&r_full) w_state_nxt = S_STREAM;
        S_FETCH:  if (w_fetch_last) w_state_nxt = S_WAIT;
        S_STREAM: if (!(&r_full)) w_state_nxt = S_WAIT;
`else
        S_WAIT:   if (bus.ks_ready) w_state_nxt = S_FETCH;
        S_FETCH:  if (w_fetch_last) w_state_nxt = S_STREAM;
        S_STREAM: if (w_accept && (bus.in_last || w_ptr_end)) w_state_nxt = S_WAIT;
`endif
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ks_next  = 1'b0;
    w_busy     = 1'b0;
    w_in_ready = 1'b0;
    w_ks_next  = (r_state == S_FETCH);
    w_busy     = (r_state != S_IDLE);
    w_in_ready = w_avail && (!r_out_valid || bus.out_ready);
  end

  // Down-counter over the capture edges of one block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_fetch_cnt <= LAST_IDX;
    else if (w_capture) r_fetch_cnt <= r_fetch_cnt - PTR_ONE;
    else                r_fetch_cnt <= LAST_IDX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_rd_ptr <= '0;
    else if (!bus.ks_initialized) r_rd_ptr <= '0;
    else if (w_accept)           r_rd_ptr <= (bus.in_last || w_ptr_end) ? '0 : r_rd_ptr + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data ^ w_ks_word;
      r_out_last  <= bus.in_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.ks_next_chunk = w_ks_next;
  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_data      = r_out_data;
  assign bus.out_last      = r_out_last;
  assign bus.busy          = w_busy;
endmodule

// File: tb/tb_salsa20_stream_xor.sv
// Directed bench for salsa20_stream_xor with a stand-in keystream generator and a
// second instance used to undo the first one's XOR.
module tb_salsa20_stream_xor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  salsa20_stream_xor_if #(.DATA_W(64)) ifa ();
  salsa20_stream_xor_if #(.DATA_W(64)) ifb ();

  salsa20_stream_xor #(.DATA_W(64), .WORDS_PER_BLOCK(8)) u_dut (.clk(clk), .rst(rst), .bus(ifa));
  salsa20_stream_xor #(.DATA_W(64), .WORDS_PER_BLOCK(8)) u_dut2 (.clk(clk), .rst(rst), .bus(ifb));

  // Words 0/7 of block 0 and word 0 of block 1 are reference Salsa20 values; the rest are distinct fillers.
  function automatic logic [63:0] ks_word(input int idx);
    logic [31:0] x;
    x = 32'(idx);
    case (idx)
      0:       ks_word = 64'ha09b7719223218a8;
      7:       ks_word = 64'h7bed3d88a8afbb94;
      8:       ks_word = 64'h3432b110b86e67d7;
      default: ks_word = {32'h5a170000 ^ x, x * 32'h9e3779b9 + 32'h7f4a7c15};
    endcase
  endfunction

  int   gen_idx = 0;
  int   cap_edges = 0;
  int   bursts = 0;
  logic prev_next = 1'b0;
  logic gen_restart;
  logic loop_en;

  always @(posedge clk) begin
    if (gen_restart) begin
      gen_idx   <= 0;
      cap_edges <= 0;
      bursts    <= 0;
      prev_next <= 1'b0;
    end else begin
      if (ifa.ks_next_chunk) begin
        gen_idx   <= gen_idx + 1;
        cap_edges <= cap_edges + 1;
        if (!prev_next) bursts <= bursts + 1;
      end
      prev_next <= ifa.ks_next_chunk;
    end
  end

  assign ifa.ks_chunk_key   = ks_word(gen_idx);
  assign ifb.ks_chunk_key   = ifa.ks_chunk_key;
  assign ifb.ks_initialized = ifa.ks_initialized;
  assign ifb.ks_ready       = ifa.ks_ready;
  assign ifb.in_valid       = loop_en & ifa.out_valid;
  assign ifb.in_data        = ifa.out_data;
  assign ifb.in_last        = ifa.out_last;
  assign ifb.out_ready      = 1'b1;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [63:0] exp;
    logic        exp_last;
  } vec_t;

  vec_t tbl [30];
  int   n_tests = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic [63:0] d, input logic l, input logic [63:0] e, input logic el);
    vec_t v;
    v.data = d; v.last = l; v.exp = e; v.exp_last = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents one word, waits (bounded) for acceptance, returns {out_valid, out_last, out_data} one cycle later.
  task automatic send(input logic [63:0] d, input logic l, output logic [65:0] res);
    int waited;
    waited = 0;
    @(negedge clk);
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    ifa.in_last  = l;
    while (!ifa.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!ifa.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send timeout: in_ready=%0b after %0d cycles, required 1", ifa.in_ready, waited);
      ifa.in_valid = 1'b0;
      res = '0;
    end else begin
      @(posedge clk);
      #1;
      res = {ifa.out_valid, ifa.out_last, ifa.out_data};
      ifa.in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [65:0] res;
    logic [63:0] ones;
    logic [63:0] pat;
    int          waited;

    ones = '1;
    rst = 1'b0;
    gen_restart = 1'b1;
    loop_en = 1'b0;
    ifa.ks_initialized = 1'b0;
    ifa.ks_ready = 1'b0;
    ifa.in_valid = 1'b0;
    ifa.in_data = '0;
    ifa.in_last = 1'b0;
    ifa.out_ready = 1'b1;

    for (int i = 0; i < 16; i++) tbl[i] = mk(64'h0, 1'b0, ks_word(i), 1'b0);
    tbl[0].exp = 64'ha09b7719223218a8;
    tbl[7].exp = 64'h7bed3d88a8afbb94;
    tbl[8].exp = 64'h3432b110b86e67d7;
    tbl[16] = mk(64'h0123456789abcdef, 1'b0, ks_word(16) ^ 64'h0123456789abcdef, 1'b0);
    tbl[17] = mk(ones, 1'b0, ~ks_word(17), 1'b0);
    tbl[18] = mk(64'h0, 1'b1, ks_word(18), 1'b1);
    tbl[19] = mk(64'h0, 1'b0, ks_word(24), 1'b0);
    tbl[20] = mk(64'hdeadbeef00000001, 1'b1, ks_word(25) ^ 64'hdeadbeef00000001, 1'b1);
    for (int i = 0; i < 8; i++) begin
      pat = {32'(i), 32'hcafef00d};
      tbl[21 + i] = mk(pat, (i == 7), ks_word(32 + i) ^ pat, (i == 7));
    end
    tbl[29] = mk(64'h0, 1'b1, ks_word(40), 1'b1);

    repeat (2) @(negedge clk);
    check("reset ks_next_chunk", 128'(ifa.ks_next_chunk), 128'(0));
    check("reset in_ready", 128'(ifa.in_ready), 128'(0));
    check("reset out_valid", 128'(ifa.out_valid), 128'(0));
    check("reset out_data", 128'(ifa.out_data), 128'(0));
    check("reset out_last", 128'(ifa.out_last), 128'(0));
    check("reset busy", 128'(ifa.busy), 128'(0));
    rst = 1'b1;
    @(negedge clk);
    gen_restart = 1'b0;
    ifa.ks_initialized = 1'b1;
    ifa.ks_ready = 1'b1;

    for (int i = 0; i < 30; i++) begin
      send(tbl[i].data, tbl[i].last, res);
      check($sformatf("vec%0d", i), {62'b0, res}, {62'b0, 1'b1, tbl[i].exp_last, tbl[i].exp});
      if (i == 15) begin
        check("capture edges after 2 blocks", 128'(cap_edges), 128'(16));
        check("fetch bursts after 2 blocks", 128'(bursts), 128'(2));
      end
    end

    // Backpressure on block 6: outputs hold, nothing accepted, next word is ptr 1.
    send(64'haaaaaaaaaaaaaaaa, 1'b0, res);
    check("bp first word", {62'b0, res}, {62'b0, 2'b10, ks_word(48) ^ 64'haaaaaaaaaaaaaaaa});
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.in_data = 64'h5555555555555555;
    ifa.in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d", k),
            128'({ifa.out_valid, ifa.in_ready, ifa.out_last, ifa.out_data}),
            128'({1'b1, 1'b0, 1'b0, ks_word(48) ^ 64'haaaaaaaaaaaaaaaa}));
    end
    @(negedge clk);
    ifa.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp next word", 128'({ifa.out_valid, ifa.out_last, ifa.out_data}),
          128'({2'b10, ks_word(49) ^ 64'h5555555555555555}));
    ifa.in_valid = 1'b0;
    ifa.ks_ready = 1'b0;
    send(64'h0f0f0f0f0f0f0f0f, 1'b1, res);
    check("bp end word", {62'b0, res}, {62'b0, 2'b11, ks_word(50) ^ 64'h0f0f0f0f0f0f0f0f});

    // Reset after four capture edges of a fetch.
    @(negedge clk);
    ifa.ks_ready = 1'b1;
    waited = 0;
    while (!ifa.ks_next_chunk && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("fetch active before reset", 128'(ifa.ks_next_chunk), 128'(1));
    rst = 1'b0;
    gen_restart = 1'b1;
    ifa.ks_initialized = 1'b0;
    ifa.ks_ready = 1'b0;
    #1;
    check("mid-fetch reset outputs",
          128'({ifa.ks_next_chunk, ifa.in_ready, ifa.out_valid, ifa.out_last, ifa.busy, ifa.out_data}),
          128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    gen_restart = 1'b0;
    loop_en = 1'b1;
    ifa.ks_initialized = 1'b1;
    ifa.ks_ready = 1'b1;

    // Both instances fetch block 0; the second undoes the first's XOR.
    send(ones, 1'b1, res);
    check("loop encrypt", {62'b0, res}, {62'b0, 2'b11, 64'h5f6488e6ddcde757});
    @(posedge clk);
    #1;
    check("loop decrypt", 128'({ifb.out_valid, ifb.out_last, ifb.out_data}), 128'({2'b11, ones}));
    check("restart capture edges", 128'(cap_edges), 128'(8));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
